// File: rtl/store_buffer.sv
// Posted store buffer: in-order drain to a handshaked memory write port.
// Optional load forwarding from pending entries when STORE_FWD_EN is defined.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int WORD  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] addr,
    input  logic [WORD-1:0] writeData,
    input  logic            memWrite,
    input  logic            finish,
    output logic [WORD-1:0] readData,
    output logic            stall,
    output logic            drained,
    output logic [WORD-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    output logic            mem_we,
    input  logic            mem_ready,
    output logic [WORD-1:0] mem_raddr,
    input  logic [WORD-1:0] mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WORD-1:0] r_addr [DEPTH];
    logic [WORD-1:0] r_data [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_finish_seen;

    logic w_push;
    logic w_pop;

    // Conservative: a same-cycle pop does not free a slot for the push.
    assign stall     = memWrite && (r_count == FULL);
    assign w_push    = memWrite && !stall;
    assign mem_we    = (r_count != '0);
    assign w_pop     = mem_we && mem_ready;
    assign mem_addr  = r_addr[r_head];
    assign mem_wdata = r_data[r_head];
    assign mem_raddr = addr;
    assign drained   = r_finish_seen && (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_finish_seen <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (finish) begin
                r_finish_seen <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset; validity comes from the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= addr;
            r_data[r_tail] <= writeData;
        end
    end

`ifdef STORE_FWD_EN
    logic            w_fwd_hit;
    logic [WORD-1:0] w_fwd_data;

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && (r_addr[idx] == addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[idx];
            end
        end
    end

    assign readData = w_fwd_hit ? w_fwd_data : mem_rdata;
`else
    assign readData = mem_rdata;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed table-driven bench for store_buffer (DEPTH=4, WORD=32).
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] writeData = '0;
    logic        memWrite = 1'b0;
    logic        finish = 1'b0;
    logic [31:0] readData;
    logic        stall;
    logic        drained;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    logic [31:0] wlog[$];

    always #5 clk = ~clk;

    assign mem_rdata = 32'hD000_0000 | mem_raddr;

    store_buffer #(.DEPTH(4), .WORD(32)) dut (
        .clk(clk), .rst(rst), .addr(addr), .writeData(writeData),
        .memWrite(memWrite), .finish(finish), .readData(readData),
        .stall(stall), .drained(drained), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we === 1'b1 && mem_ready === 1'b1) wlog.push_back(mem_addr);
    end

    typedef struct {
        logic        rst, mw, rdy, fin;
        logic [31:0] a, d;
        logic        chk, e_stall, e_we;
        logic [31:0] e_maddr, e_mwd, e_rd;
        logic        e_drn;
    } vec_t;

    vec_t vt[35];

    function automatic vec_t mk(logic r, logic mw, logic rdy, logic fin,
                                logic [31:0] a, logic [31:0] d, logic chk,
                                logic st, logic we, logic [31:0] ma,
                                logic [31:0] mwd, logic [31:0] rd, logic dr);
        vec_t v;
        v.rst = r; v.mw = mw; v.rdy = rdy; v.fin = fin; v.a = a; v.d = d;
        v.chk = chk; v.e_stall = st; v.e_we = we; v.e_maddr = ma;
        v.e_mwd = mwd; v.e_rd = rd; v.e_drn = dr;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_rd;
        logic [31:0] exp_log[12];
        logic [31:0] exp_log2[5];
        int n;
        int k;

        vt[0]  = mk(1,0,0,0,'h00,'h0,0,0,0,'h0,'h0,'h0,0);
        vt[1]  = mk(0,0,0,0,'h10,'h0,1,0,0,'h0,'h0,'hD0000010,0);
        vt[2]  = mk(0,1,1,0,'h10,'hAAAA0001,1,0,0,'h0,'h0,'hD0000010,0);
        vt[3]  = mk(0,0,1,0,'h10,'h0,1,0,1,'h10,'hAAAA0001,'hAAAA0001,0);
        vt[4]  = mk(0,0,0,0,'h10,'h0,1,0,0,'h0,'h0,'hD0000010,0);
        vt[5]  = mk(0,1,0,0,'h00,'h100,1,0,0,'h0,'h0,'hD0000000,0);
        vt[6]  = mk(0,1,0,0,'h04,'h101,1,0,1,'h00,'h100,'hD0000004,0);
        vt[7]  = mk(0,1,0,0,'h08,'h102,1,0,1,'h00,'h100,'hD0000008,0);
        vt[8]  = mk(0,1,0,0,'h0C,'h103,1,0,1,'h00,'h100,'hD000000C,0);
        vt[9]  = mk(0,1,0,0,'h10,'h104,1,1,1,'h00,'h100,'hD0000010,0);
        vt[10] = mk(0,1,1,0,'h10,'h104,1,1,1,'h00,'h100,'hD0000010,0);
        vt[11] = mk(0,1,1,0,'h10,'h104,1,0,1,'h04,'h101,'hD0000010,0);
        vt[12] = mk(0,0,1,0,'h0C,'h0,1,0,1,'h08,'h102,'h103,0);
        vt[13] = mk(0,0,1,0,'h10,'h0,1,0,1,'h0C,'h103,'h104,0);
        vt[14] = mk(0,0,1,0,'h10,'h0,1,0,1,'h10,'h104,'h104,0);
        vt[15] = mk(0,0,0,0,'h10,'h0,1,0,0,'h0,'h0,'hD0000010,0);
        vt[16] = mk(0,1,0,0,'h20,'h1,1,0,0,'h0,'h0,'hD0000020,0);
        vt[17] = mk(0,1,0,0,'h20,'h2,1,0,1,'h20,'h1,'h1,0);
        vt[18] = mk(0,0,0,0,'h20,'h0,1,0,1,'h20,'h1,'h2,0);
        vt[19] = mk(0,0,1,0,'h20,'h0,1,0,1,'h20,'h1,'h2,0);
        vt[20] = mk(0,1,1,0,'h30,'h3,1,0,1,'h20,'h2,'hD0000030,0);
        vt[21] = mk(0,0,1,0,'h30,'h0,1,0,1,'h30,'h3,'h3,0);
        vt[22] = mk(0,1,0,0,'h40,'h4,1,0,0,'h0,'h0,'hD0000040,0);
        vt[23] = mk(0,1,0,1,'h44,'h5,1,0,1,'h40,'h4,'hD0000044,0);
        vt[24] = mk(0,0,1,0,'h44,'h0,1,0,1,'h40,'h4,'h5,0);
        vt[25] = mk(0,0,1,0,'h44,'h0,1,0,1,'h44,'h5,'h5,0);
        vt[26] = mk(0,0,1,0,'h44,'h0,1,0,0,'h0,'h0,'hD0000044,1);
        vt[27] = mk(0,1,0,0,'h50,'h6,1,0,0,'h0,'h0,'hD0000050,1);
        vt[28] = mk(0,1,0,0,'h54,'h7,1,0,1,'h50,'h6,'hD0000054,0);
        vt[29] = mk(0,1,0,0,'h58,'h8,1,0,1,'h50,'h6,'hD0000058,0);
        vt[30] = mk(1,0,1,0,'h50,'h0,1,0,1,'h50,'h6,'h6,0);
        vt[31] = mk(0,0,1,0,'h54,'h0,1,0,0,'h0,'h0,'hD0000054,0);
        vt[32] = mk(0,0,1,0,'h58,'h0,1,0,0,'h0,'h0,'hD0000058,0);
        vt[33] = mk(0,0,1,1,'h00,'h0,1,0,0,'h0,'h0,'hD0000000,0);
        vt[34] = mk(0,0,1,0,'h00,'h0,1,0,0,'h0,'h0,'hD0000000,1);

        exp_log = '{'h10,'h00,'h04,'h08,'h0C,'h10,'h20,'h20,'h30,'h40,'h44,'h50};
        exp_log2 = '{'hA0,'hA4,'hA8,'hAC,'hB0};

        @(posedge clk); #1;
        for (int i = 0; i < 35; i++) begin
            rst = vt[i].rst; memWrite = vt[i].mw; mem_ready = vt[i].rdy;
            finish = vt[i].fin; addr = vt[i].a; writeData = vt[i].d;
            @(negedge clk);
            if (vt[i].chk) begin
`ifdef STORE_FWD_EN
                exp_rd = vt[i].e_rd;
`else
                exp_rd = 32'hD000_0000 | vt[i].a;
`endif
                check($sformatf("v%0d.stall", i), {31'b0, stall}, {31'b0, vt[i].e_stall});
                check($sformatf("v%0d.we", i), {31'b0, mem_we}, {31'b0, vt[i].e_we});
                check($sformatf("v%0d.drained", i), {31'b0, drained}, {31'b0, vt[i].e_drn});
                check($sformatf("v%0d.rd", i), readData, exp_rd);
                check($sformatf("v%0d.raddr", i), mem_raddr, vt[i].a);
                if (vt[i].e_we) begin
                    check($sformatf("v%0d.maddr", i), mem_addr, vt[i].e_maddr);
                    check($sformatf("v%0d.mwdata", i), mem_wdata, vt[i].e_mwd);
                end
            end
            @(posedge clk); #1;
        end

        check("log.size", wlog.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < wlog.size()) check($sformatf("log%0d", i), wlog[i], exp_log[i]);
        end

        // Fill, hold a stalled fifth store, then release memory.
        rst = 1; memWrite = 0; mem_ready = 0; finish = 0;
        @(posedge clk); #1;
        rst = 0;
        wlog.delete();
        for (int i = 0; i < 4; i++) begin
            memWrite = 1; addr = 32'hA0 + 32'(4 * i); writeData = 32'(i);
            @(posedge clk); #1;
        end
        addr = 32'hB0; writeData = 32'h4;
        @(negedge clk);
        check("full.stall", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        mem_ready = 1;
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            if (!stall) break;
            @(posedge clk); #1;
            n++;
        end
        check("release.cycles", n, 1);
        @(posedge clk); #1;
        memWrite = 0;
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            if (!mem_we) break;
            @(posedge clk); #1;
            k++;
        end
        check("drain.bound", {31'b0, mem_we}, 32'd0);
        check("log2.size", wlog.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < wlog.size()) check($sformatf("log2_%0d", i), wlog[i], exp_log2[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted store buffer between the single-cycle core's data-memory port and the backing data memory. It accepts a store (`memWrite`, `ALUResult` as address, `writeData`) every cycle without waiting on memory, and drains entries in order to a handshaked memory write port. Loads are forwarded from pending entries. It signals `drained` once the core has raised `finish` and every posted store has reached memory, so the testbench ends the run only after memory is coherent.

## Interface
- `DEPTH`, 4: entry count; power of two, ≥2.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  `WORD`  data address from core (`ALUResult`).
- `writeData`  in  `WORD`  store data from core.
- `memWrite`  in  1  core store request.
- `finish`  in  1  core halt indication.
- `readData`  out  `WORD`  load data to core.
- `stall`  out  1  store not accepted this cycle; core must hold pc and state.
- `drained`  out  1  finish seen and buffer empty.
- `mem_addr`  out  `WORD`  head entry address.
- `mem_wdata`  out  `WORD`  head entry data.
- `mem_we`  out  1  head entry valid, write request.
- `mem_ready`  in  1  memory accepts write this cycle.
- `mem_raddr`  out  `WORD`  combinational read address, equal to `addr`.
- `mem_rdata`  in  `WORD`  combinational read data from memory.

## Operation
- Circular FIFO: head and tail pointers of `$clog2(DEPTH)` bits wrapping modulo DEPTH, plus a count register of `$clog2(DEPTH)+1` bits (0..DEPTH).
- Push: `memWrite && !stall` writes {addr, writeData} at tail at the clock edge and increments tail.
- `stall = memWrite && (count == DEPTH)`. Conservative: a pop in the same cycle does not release the stall.
- Pop: `mem_we && mem_ready` advances head at the edge. `mem_we = (count != 0)`. `mem_addr`/`mem_wdata` come from the head entry only.
- Simultaneous push and pop: count unchanged and both pointers advance. Both are legal at count==1; memory receives the old head entry.
- Stores drain strictly in program order. No coalescing: two stores to one address produce two memory writes.
- Forwarding: full-width `addr` compare against all valid entries. The youngest match (closest to tail) drives `readData`; with no match, `readData = mem_rdata`. The incoming same-cycle store never forwards to itself.
- `finish_seen`: sticky register set when `finish` is high, cleared only by `rst`. `drained = finish_seen && count == 0`. Stores after finish are still accepted.

## Timing
- Push and pop take effect at the rising edge. An entry is visible to forwarding and on `mem_we` from the next cycle.
- A store reaches memory no earlier than 1 cycle after acceptance. With `mem_ready` held high the buffer sustains 1 store/cycle.
- `readData`, `stall`, and `mem_raddr` are combinational in the current cycle. `mem_we`, `mem_addr`, `mem_wdata`, and `drained` depend only on registers.
- Reset values: count=0, head=tail=0, finish_seen=0. Therefore `mem_we=0`, `drained=0`, and `stall=0` from the cycle after the reset edge. Entry contents are don't-care.
- Reset mid-drain: pending entries are discarded. A write handshaking in the same cycle as the reset edge counts as delivered to memory.
- `drained` rises 1 cycle after the pop of the last entry, or 1 cycle after `finish` if the buffer is already empty.

## Configuration
- `STORE_FWD_EN` defined: forwarding as above.
- Not defined: comparators removed and `readData = mem_rdata` always. Store-to-load hazards are then software's responsibility; the bench checks memory only after `drained`.

## Test plan
- Store 0x10←0xAAAA0001 with `mem_ready`=1 → `mem_we` high the next cycle with addr 0x10, then count 0. Reading 0x10 afterwards returns `mem_rdata`.
- `mem_ready`=0, five stores to 0x00,0x04,0x08,0x0C,0x10 with DEPTH=4 → first four accepted, `stall`=1 on the fifth until `mem_ready` rises. Memory sees the writes in order 0x00..0x10.
- With `STORE_FWD_EN`, `mem_ready`=0, stores 0x20←1 then 0x20←2, read 0x20 → `readData`=2. Without the macro, `readData`=`mem_rdata`.
- count=1, `mem_ready`=1, new store in the same cycle → count stays 1 and memory receives the old entry first.
- Two pending stores, pulse `finish`, `mem_ready`=1 → `drained` rises exactly 1 cycle after the second pop.
- `rst` with three pending entries → next cycle `mem_we`=0, `drained`=0, `stall`=0, and no further memory writes occur.
